// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants for the code-entry game blocks (entry shift register,
// code checker, game controller).
//   - CODE_W / DIGITS / NIBBLE_W : geometry of an entered code word
//   - ST_* : code_checker FSM state encoding
//   - nibble_match / popcount_digits : per-digit comparison helpers
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int CODE_W   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COMPARE = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_LOCK    = 3'd4;

    // Bit i is set when digit i of a equals digit i of b.
    function automatic logic [DIGITS-1:0] nibble_match(input logic [CODE_W-1:0] a,
                                                       input logic [CODE_W-1:0] b);
        logic [DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < DIGITS; i++) begin
            m[i] = (a[i*NIBBLE_W +: NIBBLE_W] == b[i*NIBBLE_W +: NIBBLE_W]);
        end
        return m;
    endfunction

    // Number of set bits in a digit mask (0..DIGITS).
    function automatic logic [2:0] popcount_digits(input logic [DIGITS-1:0] m);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            c = c + 3'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/code_checker_if.sv
// ---------------------------------------------------------------------------
// code_checker_if
// Bundle between the entry side (target/entry producer) and code_checker.
//   master : drives target, target_load, entered, valid_bit; reads results
//   slave  : code_checker side
// Results: match, mismatch, digits_correct, tries_left, locked,
//          score[SCORE_W-1:0], digit_hits[3:0].
// ---------------------------------------------------------------------------
interface code_checker_if #(
    parameter int SCORE_W = 8
);
    import game_pkg::*;

    logic [CODE_W-1:0]  target;
    logic               target_load;
    logic [CODE_W-1:0]  entered;
    logic               valid_bit;
    logic               match;
    logic               mismatch;
    logic [2:0]         digits_correct;
    logic [2:0]         tries_left;
    logic               locked;
    logic [SCORE_W-1:0] score;
    logic [DIGITS-1:0]  digit_hits;

    modport master (
        output target, target_load, entered, valid_bit,
        input  match, mismatch, digits_correct, tries_left, locked, score, digit_hits
    );

    modport slave (
        input  target, target_load, entered, valid_bit,
        output match, mismatch, digits_correct, tries_left, locked, score, digit_hits
    );

endinterface

// File: rtl/lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
// Loadable down-counter. A load pulse sets the count to LOCK_CYCLES-1; the
// count then decrements every cycle and parks at zero.
//   clock   : system clock, rising edge
//   rst     : asynchronous active-low reset
//   load    : restart the count
//   count   : current count value
//   expired : count has reached zero
// ---------------------------------------------------------------------------
module lockout_timer #(
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOCK_CYCLES - 1);

    // NOTE: sequential state is written with non-blocking (<=) so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/code_checker.sv
// ---------------------------------------------------------------------------
// code_checker
// Compares each newly submitted 4-digit entry against a latched target,
// reports pass/fail and per-digit hits, limits retries, imposes a timed
// lockout after MAX_TRIES failures and keeps a saturating success score.
//   clock : system clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : code_checker_if.slave (target, target_load, entered, valid_bit in;
//           match, mismatch, digits_correct, tries_left, locked, score,
//           digit_hits out)
// Build option: define CODE_CHECKER_DIGIT_HINT_EN to register the per-digit
// hit mask on digit_hits; otherwise digit_hits is tied to zero.
// ---------------------------------------------------------------------------
module code_checker
    import game_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int SCORE_W     = 8
) (
    input logic           clock,
    input logic           rst,
    code_checker_if.slave bus
);

    localparam logic [2:0]         TRIES_INIT = 3'(MAX_TRIES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [2:0]         state;
    logic               valid_q;
    logic [CODE_W-1:0]  target_q;
    logic [CODE_W-1:0]  entry_q;
    logic               match_q;
    logic               mismatch_q;
    logic               locked_q;
    logic [2:0]         digits_q;
    logic [2:0]         tries_q;
    logic [SCORE_W-1:0] score_q;

    logic               rise;
    logic [DIGITS-1:0]  eq_mask;
    logic [2:0]         eq_count;
    logic               all_equal;
    logic               lock_entry;
    logic               timer_expired;
    // The count itself only matters to other users of the timer.
    logic [15:0]        unused_timer_count;

    assign rise      = bus.valid_bit & ~valid_q;
    assign eq_mask   = nibble_match(entry_q, target_q);
    assign eq_count  = popcount_digits(eq_mask);
    assign all_equal = (eq_mask == '1);
    // Last remaining try fails in this COMPARE cycle: arm the lockout timer
    // so it holds LOCK_CYCLES-1 on the first LOCK cycle.
    assign lock_entry = (state == ST_COMPARE) && !all_equal && (tries_q == 3'd1);

    lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES),
        .CNT_W      (16)
    ) u_lockout_timer (
        .clock  (clock),
        .rst    (rst),
        .load   (lock_entry),
        .count  (unused_timer_count),
        .expired(timer_expired)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            valid_q    <= 1'b0;
            target_q   <= '0;
            entry_q    <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
            digits_q   <= '0;
            tries_q    <= TRIES_INIT;
            score_q    <= '0;
        end else begin
            valid_q <= bus.valid_bit;
            case (state)
                ST_IDLE: begin
                    // A rise wins over a simultaneous target load: the compare
                    // must see the target the user was playing against.
                    if (rise) begin
                        entry_q <= bus.entered;
                        state   <= ST_COMPARE;
                    end else if (bus.target_load) begin
                        target_q <= bus.target;
                    end
                end
                ST_COMPARE: begin
                    digits_q <= eq_count;
                    if (all_equal) begin
                        match_q <= 1'b1;
                        tries_q <= TRIES_INIT;
                        if (score_q != SCORE_MAX) begin
                            score_q <= score_q + SCORE_W'(1);
                        end
                        state <= ST_PASS;
                    end else begin
                        mismatch_q <= 1'b1;
                        tries_q    <= tries_q - 3'd1;
                        if (tries_q == 3'd1) begin
                            locked_q <= 1'b1;
                            state    <= ST_LOCK;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (!bus.valid_bit) begin
                        match_q    <= 1'b0;
                        mismatch_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    // Timeout ends the lock indication, but the FSM only
                    // leaves once the user has released valid_bit.
                    if (timer_expired) begin
                        locked_q <= 1'b0;
                        if (!bus.valid_bit) begin
                            mismatch_q <= 1'b0;
                            tries_q    <= TRIES_INIT;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CODE_CHECKER_DIGIT_HINT_EN
    logic [DIGITS-1:0] hits_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hits_q <= '0;
        end else if (state == ST_COMPARE) begin
            hits_q <= lock_entry ? '0 : eq_mask;
        end
    end

    assign bus.digit_hits = hits_q;
`else
    assign bus.digit_hits = '0;
`endif

    assign bus.match          = match_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.digits_correct = digits_q;
    assign bus.tries_left     = tries_q;
    assign bus.locked         = locked_q;
    assign bus.score          = score_q;

endmodule

// File: tb/tb_code_checker.sv
// ---------------------------------------------------------------------------
// tb_code_checker
// Self-checking bench for code_checker. Two instances share one stimulus
// stream: the default build (SCORE_W = 8) and a SCORE_W = 2 build used to
// observe score saturation. Expected values come from a transaction-level
// model (target, tries, score, last digit count) kept in this file.
// Honours CODE_CHECKER_DIGIT_HINT_EN for the digit_hits expectations.
// ---------------------------------------------------------------------------
module tb_code_checker;
    import game_pkg::*;

    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int SCORE_W     = 8;
    localparam int SCORE2_W    = 2;
    localparam int SCORE_MAX   = (1 << SCORE_W) - 1;
    localparam int SCORE2_MAX  = (1 << SCORE2_W) - 1;

`ifdef CODE_CHECKER_DIGIT_HINT_EN
    localparam bit HINT = 1'b1;
`else
    localparam bit HINT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    code_checker_if #(.SCORE_W(SCORE_W))  bus  ();
    code_checker_if #(.SCORE_W(SCORE2_W)) bus2 ();

    assign bus2.target      = bus.target;
    assign bus2.target_load = bus.target_load;
    assign bus2.entered     = bus.entered;
    assign bus2.valid_bit   = bus.valid_bit;

    code_checker #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .SCORE_W(SCORE_W)) dut (
        .clock(clk),
        .rst  (rst_n),
        .bus  (bus)
    );

    code_checker #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .SCORE_W(SCORE2_W)) dut2 (
        .clock(clk),
        .rst  (rst_n),
        .bus  (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_target;
    int          m_tries;
    int          m_score;
    int          m_score2;
    int          m_dc;
    logic [3:0]  m_hits;

    typedef struct {
        bit          do_load;
        logic [15:0] tgt;
        logic [15:0] entry;
        logic [31:0] exp_match;
        logic [31:0] exp_dc;
        logic [31:0] exp_tries;
        logic [31:0] exp_hits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] hint(input logic [3:0] m);
        return HINT ? {28'h0, m} : 32'h0;
    endfunction

    // Digits of a that equal the same digit of b; mask bit i for digit i.
    function automatic int count_hits(input logic [15:0] a, input logic [15:0] b,
                                      output logic [3:0] mask);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            mask[i] = (a[4*i +: 4] == b[4*i +: 4]);
            if (mask[i]) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_target = 16'h0000;
        m_tries  = MAX_TRIES;
        m_score  = 0;
        m_score2 = 0;
        m_dc     = 0;
        m_hits   = 4'h0;
    endtask

    task automatic check_all(input string tag, input bit em, input bit emm, input bit elk);
        check({tag, ".match"},      32'(bus.match),          32'(em));
        check({tag, ".mismatch"},   32'(bus.mismatch),       32'(emm));
        check({tag, ".digits"},     32'(bus.digits_correct), 32'(m_dc));
        check({tag, ".tries"},      32'(bus.tries_left),     32'(m_tries));
        check({tag, ".locked"},     32'(bus.locked),         32'(elk));
        check({tag, ".score"},      32'(bus.score),          32'(m_score));
        check({tag, ".score_w2"},   32'(bus2.score),         32'(m_score2));
        check({tag, ".digit_hits"}, 32'(bus.digit_hits),     32'(m_hits));
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_target(input logic [15:0] t);
        bus.target      = t;
        bus.target_load = 1'b1;
        step();
        bus.target_load = 1'b0;
        m_target        = t;
    endtask

    // One submission: raise valid_bit with an entry, check the result two
    // edges later, optionally hold valid high, then release it. A failed
    // final try either waits out the lockout or returns still in lockout.
    task automatic submit(input logic [15:0] e, input int hold, input bit wait_lock,
                          input bit co_load, input logic [15:0] co_tgt,
                          output logic [31:0] got_match, output logic [31:0] got_dc,
                          output logic [31:0] got_tries, output logic [31:0] got_hits);
        logic [3:0] mask;
        int dc;
        int n;
        bit eq;
        bit lock;
        dc = count_hits(e, m_target, mask);
        eq = (dc == 4);
        if (eq) begin
            if (m_score < SCORE_MAX) m_score++;
            if (m_score2 < SCORE2_MAX) m_score2++;
            m_tries = MAX_TRIES;
        end else begin
            m_tries--;
        end
        lock   = !eq && (m_tries == 0);
        m_dc   = dc;
        m_hits = lock ? 4'h0 : hint(mask)[3:0];

        bus.entered   = e;
        bus.valid_bit = 1'b1;
        if (co_load) begin
            bus.target      = co_tgt;
            bus.target_load = 1'b1;
        end
        step();
        bus.target_load = 1'b0;
        step();
        got_match = 32'(bus.match);
        got_dc    = 32'(bus.digits_correct);
        got_tries = 32'(bus.tries_left);
        got_hits  = 32'(bus.digit_hits);
        check_all("result", eq, !eq, lock);

        if (lock) begin
            if (!wait_lock) return;
            bus.valid_bit = 1'b0;
            n = 0;
            while (bus.locked === 1'b1 && n < LOCK_CYCLES + 8) begin
                n++;
                step();
            end
            check("lock_length", 32'(n), 32'(LOCK_CYCLES));
            m_tries = MAX_TRIES;
            check_all("unlocked", 1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                step();
                check_all("held", eq, !eq, 1'b0);
            end
            bus.valid_bit = 1'b0;
            step();
            check_all("released", 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gm, gd, gt, gh;
        logic [15:0] e;
        int sat_exp[5];
        int n;

        bus.target      = '0;
        bus.target_load = 1'b0;
        bus.entered     = '0;
        bus.valid_bit   = 1'b0;
        model_reset();

        vecs[0] = '{1'b1, 16'h1234, 16'h1234, 1, 4, 3, hint(4'hF)};
        vecs[1] = '{1'b0, 16'h0000, 16'h1299, 0, 2, 2, hint(4'hC)};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 0, 0, 1, hint(4'h0)};
        vecs[3] = '{1'b0, 16'h0000, 16'h4321, 0, 0, 0, 32'h0};
        vecs[4] = '{1'b0, 16'h0000, 16'h1F3F, 0, 2, 2, hint(4'hA)};
        vecs[5] = '{1'b1, 16'hABCD, 16'hABCD, 1, 4, 3, hint(4'hF)};
        sat_exp = '{1, 2, 3, 3, 3};

        // Power-on reset
        #2;
        apply_reset("reset");

        // Table-driven single entries (includes the 3-failure lockout)
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_load) load_target(vecs[i].tgt);
            submit(vecs[i].entry, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
            check($sformatf("vec%0d.match", i),      gm, vecs[i].exp_match);
            check($sformatf("vec%0d.digits", i),     gd, vecs[i].exp_dc);
            check($sformatf("vec%0d.tries", i),      gt, vecs[i].exp_tries);
            check($sformatf("vec%0d.digit_hits", i), gh, vecs[i].exp_hits);
        end

        // Lockout ignores target_load and valid_bit activity
        load_target(16'h1234);
        submit(16'h1299, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h0000, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h4321, 0, 1'b0, 1'b0, 16'h0, gm, gd, gt, gh);
        for (int i = 0; i < 6; i++) begin
            bus.valid_bit   = ~bus.valid_bit;
            bus.target      = 16'hAAAA;
            bus.target_load = (i == 2);
            bus.entered     = 16'h1234;
            step();
            check_all("lock_busy", 1'b0, 1'b1, 1'b1);
        end
        bus.target_load = 1'b0;
        bus.valid_bit   = 1'b0;
        n = 0;
        while (bus.locked === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("lock_busy_ends", 32'(bus.locked), 32'(0));
        m_tries = MAX_TRIES;
        check_all("lock_busy_exit", 1'b0, 1'b0, 1'b0);
        submit(16'h1234, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        check("target_kept", gm, 32'(1));

        // valid_bit still high at expiry: locked drops, FSM waits for release
        submit(16'h1299, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h0000, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h4321, 0, 1'b0, 1'b0, 16'h0, gm, gd, gt, gh);
        repeat (LOCK_CYCLES + 4) step();
        check_all("lock_wait_valid", 1'b0, 1'b1, 1'b0);
        bus.valid_bit = 1'b0;
        step();
        m_tries = MAX_TRIES;
        check_all("lock_wait_exit", 1'b0, 1'b0, 1'b0);

        // Rise coincident with target_load: old target used, load dropped
        submit(16'h1234, 0, 1'b1, 1'b1, 16'h5555, gm, gd, gt, gh);
        check("coincident.match", gm, 32'(1));
        submit(16'h5555, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        check("after_drop.match", gm, 32'(0));
        submit(16'h1234, 2, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);

        // Reset in the middle of a lockout (timer at 5)
        submit(16'h1299, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h0000, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        submit(16'h4321, 0, 1'b0, 1'b0, 16'h0, gm, gd, gt, gh);
        bus.valid_bit = 1'b0;
        repeat (LOCK_CYCLES - 1 - 5) step();
        apply_reset("reset_mid_lock");
        // Stored target was cleared to zero by reset
        submit(16'h0000, 0, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
        check("reset_target_zero", gm, 32'(1));

        // Score saturation on the SCORE_W = 2 instance
        apply_reset("reset_sat");
        load_target(16'h1234);
        for (int i = 0; i < 5; i++) begin
            submit(16'h1234, 1, 1'b1, 1'b0, 16'h0, gm, gd, gt, gh);
            check($sformatf("saturate%0d", i), 32'(bus2.score), 32'(sat_exp[i]));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            int sel;
            int pos;
            if ($urandom_range(0, 3) == 0) load_target(16'($urandom));
            sel = int'($urandom_range(0, 2));
            pos = int'($urandom_range(0, 3));
            case (sel)
                0:       e = m_target;
                1:       e = m_target ^ (16'($urandom_range(1, 15)) << (4 * pos));
                default: e = 16'($urandom);
            endcase
            submit(e, int'($urandom_range(0, 2)), 1'b1, ($urandom_range(0, 9) == 0),
                   16'($urandom), gm, gd, gt, gh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
